// File: rtl/dsp_result_capture_pkg.sv
// rtl/dsp_result_capture_pkg.sv - MISR constants, capture state type and report frame byte selector
package dsp_hwtest_pkg;

   localparam logic [63:0] MISR_SEED   = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MISR_POLY   = 64'h0000_0000_0000_001B;
   localparam int          FRAME_BYTES = 12;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_SEND,
      ST_DONE
   } cap_state_t;

   // Frame is the signature MSB first followed by the capture count MSB first.
   function automatic logic [7:0] frame_byte(input logic [63:0] sig, input logic [31:0] cnt,
                                             input logic [3:0] idx);
      logic [95:0] frame;
      frame      = {sig, cnt};
      frame_byte = 8'h00;
      for (int i = 0; i < FRAME_BYTES; i++) begin
         if (idx == 4'(i)) frame_byte = frame[8*(FRAME_BYTES-1-i) +: 8];
      end
   endfunction

endpackage

// File: rtl/dsp_result_capture_if.sv
// rtl/dsp_result_capture_if.sv - stimulus/result capture inputs and UART byte stream of the capture stage
interface dsp_result_capture_if #(
   parameter int Z_WIDTH = 54
);
   logic               vec_valid;
   logic [Z_WIDTH-1:0] z;
   logic [7:0]         tx_data;
   logic               tx_valid;
   logic               tx_ready;

   modport master (
      input  vec_valid, z, tx_ready,
      output tx_data, tx_valid
   );

   modport slave (
      output vec_valid, z, tx_ready,
      input  tx_data, tx_valid
   );
endinterface

// File: rtl/dsp_result_capture_misr64.sv
// rtl/dsp_result_capture_misr64.sv - 64-bit MISR with seed load, folding one 64-bit word per enable
module misr64
   import dsp_hwtest_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        en,
   input  logic [63:0] din,
   output logic [63:0] sig
);

   always_ff @(posedge clk) begin
      if (rst || load) begin
         sig <= MISR_SEED;
      end else if (en) begin
         sig <= {sig[62:0], 1'b0} ^ (sig[63] ? MISR_POLY : 64'h0) ^ din;
      end
   end

endmodule

// File: rtl/dsp_result_capture.sv
// rtl/dsp_result_capture.sv - captures DUT results into a MISR and streams signature plus count to the UART
module dsp_result_capture
   import dsp_hwtest_pkg::*;
#(
   parameter int          Z_WIDTH     = 54,
   parameter int          LATENCY     = 0,
   parameter logic [31:0] NUM_VECTORS = 32'd1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   dsp_result_capture_if.master bus,
   output logic                 busy,
   output logic                 done
);

   cap_state_t         state;
   logic [31:0]        launched;
   logic [31:0]        captured;
   logic [3:0]         byte_idx;
   logic               tx_valid_q;
   logic [63:0]        sig;
   logic [Z_WIDTH-1:0] z_s;
   logic               run_load;
   logic               accept;
   logic               cap_en;

   assign z_s      = bus.z;
   assign run_load = start && (state == ST_IDLE || state == ST_DONE);
   assign accept   = (state == ST_CAPTURE) && bus.vec_valid && (launched < NUM_VECTORS);

   // Capture alignment comes only from this delay line; z is not qualified by anything else.
   generate
      if (LATENCY == 0) begin : g_no_delay
         assign cap_en = accept;
      end else begin : g_delay
         logic [LATENCY-1:0] dly;
         always_ff @(posedge clk) begin
            if (rst || run_load) begin
               dly <= '0;
            end else begin
               dly[0] <= accept;
               for (int i = 1; i < LATENCY; i++) dly[i] <= dly[i-1];
            end
         end
         assign cap_en = dly[LATENCY-1] && (state == ST_CAPTURE);
      end
   endgenerate

   misr64 u_misr (
      .clk  (clk),
      .rst  (rst),
      .load (run_load),
      .en   (cap_en),
      .din  (64'(z_s)),
      .sig  (sig)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         launched   <= '0;
         captured   <= '0;
         byte_idx   <= '0;
         tx_valid_q <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state    <= ST_CAPTURE;
                  launched <= '0;
                  captured <= '0;
                  byte_idx <= '0;
                  busy     <= 1'b1;
                  done     <= 1'b0;
               end
            end
            ST_CAPTURE: begin
               if (accept) launched <= launched + 32'd1;
               if (cap_en) begin
                  captured <= captured + 32'd1;
                  if (captured == NUM_VECTORS - 32'd1) begin
                     state      <= ST_SEND;
                     tx_valid_q <= 1'b1;
                  end
               end
            end
            ST_SEND: begin
               if (bus.tx_ready) begin
                  if (byte_idx == 4'(FRAME_BYTES - 1)) begin
                     state      <= ST_DONE;
                     tx_valid_q <= 1'b0;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                  end else begin
                     byte_idx <= byte_idx + 4'd1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Signature and count are frozen during SEND, so the byte mux is stable while stalled.
   assign bus.tx_valid = tx_valid_q;
   assign bus.tx_data  = tx_valid_q ? frame_byte(sig, captured, byte_idx) : 8'h00;

endmodule

// File: tb/tb_dsp_result_capture.sv
// tb/tb_dsp_result_capture.sv - scoreboard bench with randomized runs against a reference MISR model
module tb_dsp_result_capture;

   localparam int NI = 3;
   localparam int ZW = 54;

   function automatic int lat_of(input int k);
      return (k == 0) ? 0 : (k == 1) ? 2 : 3;
   endfunction

   function automatic int nv_of(input int k);
      return (k == 0) ? 1 : (k == 1) ? 4 : 1024;
   endfunction

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_v [NI];
   logic          vv_v    [NI];
   logic [ZW-1:0] z_v     [NI];
   logic          ready_v [NI];
   wire  [7:0]    txd_w   [NI];
   wire  [NI-1:0] txv_w;
   wire  [NI-1:0] busy_w;
   wire  [NI-1:0] done_w;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      dsp_result_capture_if #(.Z_WIDTH(ZW)) bus ();
      assign bus.vec_valid = vv_v[g];
      assign bus.z         = z_v[g];
      assign bus.tx_ready  = ready_v[g];
      assign txd_w[g]      = bus.tx_data;
      assign txv_w[g]      = bus.tx_valid;

      dsp_result_capture #(
         .Z_WIDTH     (ZW),
         .LATENCY     (lat_of(g)),
         .NUM_VECTORS (32'(nv_of(g)))
      ) u_dut (
         .clk   (clk),
         .rst   (rst),
         .start (start_v[g]),
         .bus   (bus),
         .busy  (busy_w[g]),
         .done  (done_w[g])
      );
   end

   logic [7:0] exp_q[$];
   int         n_checks   = 0;
   int         n_errors   = 0;
   int         sel        = 0;
   int         bytes_seen = 0;
   bit         holding    = 1'b0;
   logic [7:0] held;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] misr_step(input logic [63:0] s, input logic [ZW-1:0] z);
      return (s << 1) ^ ((s >> 63) * 64'h1B) ^ 64'(z);
   endfunction

   function automatic logic [ZW-1:0] rand_z();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[ZW-1:0];
   endfunction

   task automatic push_frame(input logic [63:0] s, input logic [31:0] cnt);
      for (int i = 0; i < 8; i++) exp_q.push_back(s[8*(7-i) +: 8]);
      for (int i = 0; i < 4; i++) exp_q.push_back(cnt[8*(3-i) +: 8]);
   endtask

   task automatic push_const(input logic [7:0] b7);
      for (int i = 0; i < 7; i++) exp_q.push_back(8'hFF);
      exp_q.push_back(b7);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h01);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         holding = 1'b0;
      end else begin
         if (holding) begin
            check("stall_tx_valid", txv_w[sel], 1);
            check("stall_tx_data", txd_w[sel], held);
            holding = 1'b0;
         end
         if (txv_w[sel]) begin
            if (ready_v[sel]) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_byte: got %0h expected no byte", txd_w[sel]);
               end else begin
                  check($sformatf("frame_byte%0d", bytes_seen), txd_w[sel], exp_q.pop_front());
               end
               bytes_seen++;
            end else begin
               holding = 1'b1;
               held    = txd_w[sel];
            end
         end
      end
   end

   task automatic run(input int k, input bit rnd, input logic [ZW-1:0] fixed_z, input bit use_model,
                      input bit extras, input bit stall, input bit rnd_ready, input int abort_at);
      int            lat, nv, t, len, c, budget, stall_left;
      bit            stalled, aborted;
      int            launch[$];
      bit            vs[$];
      logic [ZW-1:0] zs[$];
      logic [63:0]   s;

      lat = lat_of(k);
      nv  = nv_of(k);
      t   = 0;
      for (int i = 0; i < nv; i++) begin
         if (rnd) t += $urandom_range(0, 2);
         launch.push_back(t);
         t++;
      end
      len = t + 3 + lat + 4;
      for (int i = 0; i < len; i++) begin
         vs.push_back(1'b0);
         zs.push_back(rnd ? rand_z() : fixed_z);
      end
      if (extras) for (int i = 0; i < 3; i++) vs[t+i] = 1'b1;
      s = 64'hFFFF_FFFF_FFFF_FFFF;
      foreach (launch[i]) begin
         vs[launch[i]] = 1'b1;
         s = misr_step(s, zs[launch[i] + lat]);
      end
      if (use_model) push_frame(s, 32'(nv));

      sel        = k;
      bytes_seen = 0;
      @(posedge clk); #1;
      start_v[k] = 1'b1;
      ready_v[k] = 1'b1;
      @(posedge clk); #1;
      start_v[k] = 1'b0;
      check("busy_after_start", busy_w[k], 1);
      check("done_after_start", done_w[k], 0);

      stall_left = 0;
      stalled    = 1'b0;
      aborted    = 1'b0;
      budget     = len + 400;
      c          = 0;
      forever begin
         if (c == t + lat - 1) check("tx_valid_before_last_capture", txv_w[k], 0);
         if (c == t + lat) check("tx_valid_after_last_capture", txv_w[k], 1);
         if (abort_at >= 0 && bytes_seen == abort_at) begin
            rst        = 1'b1;
            ready_v[k] = 1'b0;
            vv_v[k]    = 1'b0;
            @(posedge clk); #1;
            exp_q.delete();
            check("rst_tx_valid", txv_w[k], 0);
            check("rst_busy", busy_w[k], 0);
            check("rst_tx_data", txd_w[k], 0);
            rst     = 1'b0;
            aborted = 1'b1;
            break;
         end
         if (c >= len && done_w[k]) break;
         if (c > budget) begin
            n_checks++;
            n_errors++;
            $display("FAIL run_timeout: got done=%0b expected done=1 within %0d cycles", done_w[k], budget);
            break;
         end
         vv_v[k]    = (c < len) ? vs[c] : 1'b0;
         z_v[k]     = (c < len) ? zs[c] : '0;
         start_v[k] = extras && (c == 1);
         if (stall && !stalled && bytes_seen == 3) begin
            stalled    = 1'b1;
            stall_left = 5;
         end
         ready_v[k] = (stall_left > 0) ? 1'b0 : (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
         if (stall_left > 0) stall_left--;
         @(posedge clk); #1;
         c++;
      end

      vv_v[k]    = 1'b0;
      start_v[k] = 1'b0;
      if (!aborted) begin
         check("done_at_end", done_w[k], 1);
         check("busy_at_end", busy_w[k], 0);
         check("tx_valid_at_end", txv_w[k], 0);
         check("frame_complete", exp_q.size(), 0);
         repeat (3) @(posedge clk);
         #1;
         check("done_holds", done_w[k], 1);
      end
      if (stall) check("stall_seen", stalled, 1);
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         start_v[k] = 1'b0;
         vv_v[k]    = 1'b0;
         z_v[k]     = '0;
         ready_v[k] = 1'b0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         check("reset_tx_valid", txv_w[k], 0);
         check("reset_tx_data", txd_w[k], 0);
         check("reset_busy", busy_w[k], 0);
         check("reset_done", done_w[k], 0);
      end
      rst = 1'b0;

      push_const(8'hE5);
      run(0, 1'b0, 54'h0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      push_const(8'hE4);
      run(0, 1'b0, 54'h1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      run(0, 1'b1, 54'h0, 1'b1, 1'b1, 1'b0, 1'b1, -1);
      run(1, 1'b1, 54'h0, 1'b1, 1'b0, 1'b1, 1'b0, -1);
      repeat (4) run(1, 1'b1, 54'h0, 1'b1, 1'b0, 1'b0, 1'b1, -1);
      run(1, 1'b1, 54'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6);
      run(1, 1'b1, 54'h0, 1'b1, 1'b0, 1'b0, 1'b1, -1);
      run(2, 1'b1, 54'h0, 1'b1, 1'b1, 1'b0, 1'b1, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dsp_result_capture.md
# dsp_result_capture

Downstream capture stage for DSP primitive hardware tests. Samples the Z output of the device under test (e.g. a bypass-configured 18x18 multiply-add/sub wrapper) for a programmed number of stimulus vectors and folds each result into a 64-bit MISR signature. It then streams the signature and the capture count as bytes to the board's UART transmitter. The host compares the signature against a simulation-generated golden value.

## Interface
Parameters:
- Z_WIDTH, 54, width of the DUT result bus.
- LATENCY, 0, cycles from stimulus launch to valid Z; 0 for all-BYPASS DUTs, max 8.
- NUM_VECTORS, 1024, vectors captured per run; range 1 to 2^32-1.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
- vec_valid  in  1  the stimulus generator launched a vector into the DUT this cycle.
- z  in  Z_WIDTH  DUT result, valid LATENCY cycles after its vec_valid.
- tx_data  out  8  byte to the UART.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  the UART accepts the byte when tx_valid && tx_ready.
- busy  out  1  high in CAPTURE and SEND.
- done  out  1  high in DONE.

## Operation
- States: IDLE, CAPTURE, SEND, DONE. Reset enters IDLE.
- IDLE or DONE + start: go to CAPTURE. Load misr = MISR_SEED (64'hFFFF_FFFF_FFFF_FFFF). Clear launched and captured (32-bit each).
- CAPTURE:
  - vec_valid is accepted while launched < NUM_VECTORS; each accepted vec_valid increments launched.
  - vec_valid is ignored once launched reaches NUM_VECTORS, and in every other state.
  - Accepted valids pass through a LATENCY-deep shift register to form cap_en; LATENCY=0 uses vec_valid gated by acceptance directly.
- On cap_en:
  - misr <= {misr[62:0],1'b0} ^ (misr[63] ? MISR_POLY : 0) ^ zero_extend(z).
  - MISR_POLY = 64'h0000_0000_0000_001B.
  - captured increments.
- When the capture that makes captured == NUM_VECTORS occurs, go to SEND.
- SEND emits 12 bytes, then goes to DONE:
  - misr[63:56] down to misr[7:0] (8 bytes),
  - then captured[31:24] down to captured[7:0] (4 bytes).
- start is ignored in CAPTURE and SEND. vec_valid arriving during SEND or DONE has no effect.
- rst at any point, including mid-SEND, returns to IDLE. Outputs are zeroed next cycle; a partially sent frame is abandoned.

## Timing
- Reset values: tx_data=0, tx_valid=0, busy=0, done=0. misr=seed, counters=0.
- start sampled at edge N: busy=1 from N+1; vec_valid is accepted from N+1.
- Last capture at edge M: tx_valid=1 with byte 0 from M+1.
- Handshake:
  - tx_data stays stable and tx_valid stays high until tx_valid && tx_ready.
  - The next byte is presented in the cycle after acceptance, so full rate is one byte per cycle.
  - tx_valid never drops mid-frame except on rst.
- Acceptance of byte 11 at edge K: tx_valid=0, busy=0, done=1 from K+1.
- done holds until start or rst.
- Gaps in vec_valid are allowed; alignment comes only from the delay line.

## Structure
- Package dsp_hwtest_pkg holds:
  - MISR_SEED, MISR_POLY, FRAME_BYTES=12;
  - state enum cap_state_t.
- Sub-module misr64: clk, rst, load, en, din[63:0], sig[63:0]. It implements the seed load and update rule; the top zero-extends z.
- The top holds the FSM, delay line, counters and byte mux (byte index 0–11, 4-bit).

## Test plan
- LATENCY=0, NUM_VECTORS=1, z=0 with one vec_valid -> bytes FF FF FF FF FF FF FF E5 00 00 00 01, then done=1.
- Same, z=54'h1 -> signature byte 7 = E4; all other bytes identical.
- LATENCY=2, NUM_VECTORS=4, vec_valid with 1-cycle gaps; z = 54'h0 except in the cycle two cycles after each valid -> signature equals the software MISR model; the count bytes read 00 00 00 04.
- tx_ready held low 5 cycles on byte 3 -> tx_data/tx_valid stable throughout; total frame still 12 bytes in order.
- start pulsed during CAPTURE and 3 extra vec_valid after the count is reached -> run unaffected; the count bytes read 00 00 04 00 for NUM_VECTORS=1024.
- rst asserted at byte 6 of SEND -> tx_valid=0 and busy=0 next cycle; a following start and run produce a full correct frame.
